// File: rtl/charlie_scan_scheduler_if.sv
// Bus between the SPI register file (master side) and the charlieplex scan
// scheduler (slave side): scan configuration, double-buffered frame commit
// and the status/drive outputs toward the LED driver.
interface charlie_scan_scheduler_if #(
   parameter int DWELL_W = 8
);
   logic               cfg_enable;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [DWELL_W-1:0] cfg_brightness;
   logic [63:0]        frame_in;
   logic               frame_commit;

   logic [5:0]         charlie_index;
   logic               led_on;
   logic [63:0]        active_frame;
   logic               frame_start;
   logic               commit_pending;
   logic               busy;

   modport master (
      output cfg_enable,
      output cfg_dwell,
      output cfg_brightness,
      output frame_in,
      output frame_commit,
      input  charlie_index,
      input  led_on,
      input  active_frame,
      input  frame_start,
      input  commit_pending,
      input  busy
   );

   modport slave (
      input  cfg_enable,
      input  cfg_dwell,
      input  cfg_brightness,
      input  frame_in,
      input  frame_commit,
      output charlie_index,
      output led_on,
      output active_frame,
      output frame_start,
      output commit_pending,
      output busy
   );
endinterface

// File: rtl/charlie_scan_scheduler.sv
// Charlieplex scan scheduler: walks the 6-bit LED index through all 64
// positions, each slot lasting cfg_dwell+1 cycles with cfg_brightness
// on-cycles, followed by BLANK_CYCLES dark cycles to avoid ghosting.
// Frame images are double-buffered and swapped only at a frame boundary.
// Optional build macro SCAN_SKIP_EN: unlit slots take a single cycle and
// get no blanking gap, shortening frames that are mostly dark.
module charlie_scan_scheduler #(
   parameter int DWELL_W      = 8,
   parameter int BLANK_CYCLES = 2,
   parameter int LED_COUNT    = 64
) (
   input logic                     clk,
   input logic                     rst_n,
   charlie_scan_scheduler_if.slave bus
);

   localparam logic [5:0] IDX_LAST   = 6'(LED_COUNT - 1);
   localparam int         BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   state_t               r_state;
   logic [5:0]           r_index;
   logic [DWELL_W-1:0]   r_slotCnt;
   logic [BLANK_W-1:0]   r_blankCnt;
   logic [DWELL_W-1:0]   r_dwell;
   logic [DWELL_W-1:0]   r_bright;
   logic [63:0]          r_activeFrame;
   logic                 r_commitPending;
   logic                 r_ledOn;
   logic                 r_frameStart;
   logic                 r_busy;

   state_t               w_nextState;
   logic [5:0]           w_nextIndex;
   logic [DWELL_W-1:0]   w_nextSlotCnt;
   logic [BLANK_W-1:0]   w_nextBlankCnt;
   logic [DWELL_W-1:0]   w_nextDwell;
   logic [DWELL_W-1:0]   w_nextBright;
   logic [63:0]          w_nextFrame;
   logic                 w_nextPending;
   logic                 w_nextLedOn;
   logic                 w_newSlot;
   logic                 w_boundary;
   logic                 w_apply;
   logic                 w_skip;

   // State register of the scan sequencer; reset parks it in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state, slot timing, frame swap and next output values. Every
   // output is computed here one cycle early so that it can be registered.
   always_comb begin
      w_nextState    = r_state;
      w_nextIndex    = r_index;
      w_nextSlotCnt  = r_slotCnt;
      w_nextBlankCnt = r_blankCnt;
      w_nextDwell    = r_dwell;
      w_nextBright   = r_bright;
      w_newSlot      = 1'b0;
      w_boundary     = 1'b0;
      w_skip         = 1'b0;

`ifdef SCAN_SKIP_EN
      w_skip = (r_state == ST_SCAN) && !r_activeFrame[r_index];
`endif

      if (!bus.cfg_enable) begin
         w_nextState    = ST_IDLE;
         w_nextIndex    = '0;
         w_nextSlotCnt  = '0;
         w_nextBlankCnt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_nextState   = ST_SCAN;
               w_nextIndex   = '0;
               w_nextSlotCnt = '0;
               w_newSlot     = 1'b1;
               w_boundary    = 1'b1;
            end
            ST_SCAN: begin
               if (w_skip || (r_slotCnt == r_dwell)) begin
                  if (w_skip || (BLANK_CYCLES == 0)) begin
                     w_nextState   = ST_SCAN;
                     w_nextIndex   = r_index + 6'd1;
                     w_nextSlotCnt = '0;
                     w_newSlot     = 1'b1;
                     w_boundary    = (r_index == IDX_LAST);
                  end else begin
                     w_nextState    = ST_BLANK;
                     w_nextBlankCnt = '0;
                  end
               end else begin
                  w_nextSlotCnt = r_slotCnt + DWELL_W'(1);
               end
            end
            ST_BLANK: begin
               if (r_blankCnt == BLANK_LAST) begin
                  w_nextState   = ST_SCAN;
                  w_nextIndex   = r_index + 6'd1;
                  w_nextSlotCnt = '0;
                  w_newSlot     = 1'b1;
                  w_boundary    = (r_index == IDX_LAST);
               end else begin
                  w_nextBlankCnt = r_blankCnt + BLANK_W'(1);
               end
            end
            default: begin
               w_nextState   = ST_IDLE;
               w_nextIndex   = '0;
               w_nextSlotCnt = '0;
            end
         endcase
      end

      if (w_newSlot) begin
         w_nextDwell  = bus.cfg_dwell;
         w_nextBright = bus.cfg_brightness;
      end

      // While idle nothing is being displayed, so a commit can land at once;
      // while scanning it waits for the wrap into index 0.
      w_apply       = ((r_state == ST_IDLE) || w_boundary) && (r_commitPending || bus.frame_commit);
      w_nextFrame   = w_apply ? bus.frame_in : r_activeFrame;
      w_nextPending = w_apply ? 1'b0 : (bus.frame_commit | r_commitPending);
      w_nextLedOn   = (w_nextState == ST_SCAN) && w_nextFrame[w_nextIndex] &&
                      (w_nextSlotCnt < w_nextBright);
   end

   // Datapath and registered outputs: index, counters, latched slot config,
   // displayed frame, commit flag and the driver-facing strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_index         <= '0;
         r_slotCnt       <= '0;
         r_blankCnt      <= '0;
         r_dwell         <= '0;
         r_bright        <= '0;
         r_activeFrame   <= '0;
         r_commitPending <= 1'b0;
         r_ledOn         <= 1'b0;
         r_frameStart    <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         r_index         <= w_nextIndex;
         r_slotCnt       <= w_nextSlotCnt;
         r_blankCnt      <= w_nextBlankCnt;
         r_dwell         <= w_nextDwell;
         r_bright        <= w_nextBright;
         r_activeFrame   <= w_nextFrame;
         r_commitPending <= w_nextPending;
         r_ledOn         <= w_nextLedOn;
         r_frameStart    <= w_boundary;
         r_busy          <= (w_nextState != ST_IDLE);
      end
   end

   assign bus.charlie_index  = r_index;
   assign bus.led_on         = r_ledOn;
   assign bus.active_frame   = r_activeFrame;
   assign bus.frame_start    = r_frameStart;
   assign bus.commit_pending = r_commitPending;
   assign bus.busy           = r_busy;

endmodule

// File: tb/tb_charlie_scan_scheduler.sv
// Self-checking bench for charlie_scan_scheduler. A frame-level model tracks
// the position inside the current frame as a plain cycle offset and derives
// index, slot position and lit state from per-slot lengths. Honours
// SCAN_SKIP_EN when the bench is built with it.
module tb_charlie_scan_scheduler;

   localparam int DWELL_W = 8;
   localparam int BLANK   = 2;
   localparam int LIMIT   = 5000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int total = 0;
   int bad   = 0;

   charlie_scan_scheduler_if #(.DWELL_W(DWELL_W)) bus ();

   charlie_scan_scheduler #(
      .DWELL_W      (DWELL_W),
      .BLANK_CYCLES (BLANK),
      .LED_COUNT    (64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   bit          mRunning;
   int          mT;
   logic [63:0] mFrame;
   bit          mPending;
   int          mDwell;
   int          mBright;
   int          expIdx;
   int          expPos;
   bit          expLed;
   logic [9:0]  expVec;
   logic [9:0]  obsVec;

   assign obsVec = {bus.charlie_index, bus.led_on, bus.frame_start, bus.commit_pending, bus.busy};

   function automatic int slotLen(input logic [63:0] fr, input int i);
      int len;
      len = mDwell + 1 + BLANK;
`ifdef SCAN_SKIP_EN
      if (fr[i] == 1'b0) len = 1;
`endif
      return len;
   endfunction

   function automatic int frameLen(input logic [63:0] fr);
      int sum;
      sum = 0;
      for (int i = 0; i < 64; i++) sum += slotLen(fr, i);
      return sum;
   endfunction

   task automatic modelOutputs();
      int  acc;
      bit  found;
      acc    = 0;
      found  = 0;
      expIdx = 0;
      expPos = 0;
      if (mRunning) begin
         for (int i = 0; i < 64; i++) begin
            if (!found) begin
               if (mT < acc + slotLen(mFrame, i)) begin
                  expIdx = i;
                  expPos = mT - acc;
                  found  = 1;
               end else begin
                  acc += slotLen(mFrame, i);
               end
            end
         end
      end
      expLed = mRunning && mFrame[expIdx] && (expPos <= mDwell) && (expPos < mBright);
      expVec = {6'(expIdx), expLed, (mRunning && (mT == 0)), mPending, mRunning};
   endtask

   task automatic modelReset();
      mRunning = 0;
      mT       = 0;
      mFrame   = '0;
      mPending = 0;
      mDwell   = 0;
      mBright  = 0;
      modelOutputs();
   endtask

   task automatic modelEdge();
      bit apply;
      int flen;
      flen  = frameLen(mFrame);
      apply = 0;
      if (!mRunning) apply = mPending || bus.frame_commit;
      else if (bus.cfg_enable && (mT + 1 == flen)) apply = mPending || bus.frame_commit;
      if (bus.cfg_enable) begin
         if (!mRunning) begin
            mRunning = 1;
            mT       = 0;
            mDwell   = int'(bus.cfg_dwell);
            mBright  = int'(bus.cfg_brightness);
         end else begin
            mT = (mT + 1) % flen;
         end
      end else begin
         mRunning = 0;
         mT       = 0;
      end
      if (apply) begin
         mFrame   = bus.frame_in;
         mPending = 0;
      end else if (bus.frame_commit) begin
         mPending = 1;
      end
      modelOutputs();
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic test_reset();
      bus.cfg_enable     = 1'b0;
      bus.cfg_dwell      = 8'd3;
      bus.cfg_brightness = 8'd4;
      bus.frame_in       = '0;
      bus.frame_commit   = 1'b0;
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      total++;
      if (obsVec !== expVec || bus.active_frame !== mFrame) begin
         bad++;
         $display("[TB] FAIL reset_state: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      total++;
      if (obsVec !== expVec || bus.active_frame !== mFrame) begin
         bad++;
         $display("[TB] FAIL idle_after_reset: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
      end
   endtask

   task automatic test_dark_scan();
      int firstStart;
      int secondStart;
      int wantPeriod;
      firstStart  = -1;
      secondStart = -1;
`ifdef SCAN_SKIP_EN
      wantPeriod = 64;
`else
      wantPeriod = 64 * (3 + 1 + BLANK);
`endif
      bus.cfg_dwell      = 8'd3;
      bus.cfg_brightness = 8'd4;
      bus.cfg_enable     = 1'b1;
      for (int c = 0; c < 2 * wantPeriod + 4; c++) begin
         tick();
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL dark_scan c=%0d: got vec=%h frame=%h, want vec=%h frame=%h", c, obsVec, bus.active_frame, expVec, mFrame);
         end
         if (bus.frame_start === 1'b1) begin
            if (firstStart < 0) firstStart = c;
            else if (secondStart < 0) secondStart = c;
         end
      end
      total++;
      if (secondStart - firstStart !== wantPeriod || firstStart !== 0) begin
         bad++;
         $display("[TB] FAIL frame_period: got first=%0d period=%0d, want first=0 period=%0d", firstStart, secondStart - firstStart, wantPeriod);
      end
   endtask

   task automatic test_single_led();
      int lit;
      int flen;
      lit = 0;
      bus.cfg_enable = 1'b0;
      tick();
      total++;
      if (obsVec !== expVec || bus.active_frame !== mFrame) begin
         bad++;
         $display("[TB] FAIL single_idle: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
      end
      bus.frame_in       = 64'h1;
      bus.frame_commit   = 1'b1;
      bus.cfg_dwell      = 8'd3;
      bus.cfg_brightness = 8'd2;
      tick();
      bus.frame_commit = 1'b0;
      total++;
      if (bus.active_frame !== 64'h1 || bus.commit_pending !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_commit: got frame=%h pending=%b, want frame=%h pending=0", bus.active_frame, bus.commit_pending, 64'h1);
      end
      bus.cfg_enable = 1'b1;
`ifdef SCAN_SKIP_EN
      flen = (3 + 1 + BLANK) + 63;
`else
      flen = 64 * (3 + 1 + BLANK);
`endif
      for (int c = 0; c < flen; c++) begin
         tick();
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL single_led c=%0d: got vec=%h frame=%h, want vec=%h frame=%h", c, obsVec, bus.active_frame, expVec, mFrame);
         end
         if (bus.led_on === 1'b1) lit++;
      end
      total++;
      if (lit !== 2) begin
         bad++;
         $display("[TB] FAIL lit_count: got %0d lit cycles, want 2", lit);
      end
   endtask

   task automatic test_mid_frame_commit();
      logic [63:0] frameA;
      logic [63:0] frameB;
      int guard;
      frameA = {$urandom, $urandom} | 64'h10;
      frameB = {$urandom, $urandom} | 64'h1;
      bus.frame_in = frameA;
      guard = 0;
      while (expIdx != 20 && guard < LIMIT) begin
         tick();
         guard++;
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL seek20: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
         end
      end
      bus.frame_commit = 1'b1;
      tick();
      bus.frame_commit = 1'b0;
      total++;
      if (bus.commit_pending !== 1'b1 || bus.active_frame !== 64'h1) begin
         bad++;
         $display("[TB] FAIL pending_set: got pending=%b frame=%h, want pending=1 frame=%h", bus.commit_pending, bus.active_frame, 64'h1);
      end
      guard = 0;
      while (expIdx != 50 && guard < LIMIT) begin
         tick();
         guard++;
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL seek50: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
         end
      end
      bus.frame_in = frameB;
      guard = 0;
      while (mT != 0 && guard < LIMIT) begin
         tick();
         guard++;
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL wait_boundary: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
         end
      end
      total++;
      if (bus.active_frame !== frameB || bus.commit_pending !== 1'b0 || guard >= LIMIT) begin
         bad++;
         $display("[TB] FAIL boundary_apply: got frame=%h pending=%b, want frame=%h pending=0", bus.active_frame, bus.commit_pending, frameB);
      end
   endtask

   task automatic test_boundary_commit();
      logic [63:0] frameC;
      int guard;
      frameC = {$urandom, $urandom} | 64'h2000_0000_0000;
      bus.frame_in = frameC;
      guard = 0;
      while (!(mRunning && (mT + 1 == frameLen(mFrame))) && guard < LIMIT) begin
         tick();
         guard++;
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL seek_last: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
         end
      end
      bus.frame_commit = 1'b1;
      tick();
      bus.frame_commit = 1'b0;
      total++;
      if (bus.active_frame !== frameC || bus.commit_pending !== 1'b0 || bus.frame_start !== 1'b1) begin
         bad++;
         $display("[TB] FAIL edge_commit: got frame=%h pending=%b start=%b, want frame=%h pending=0 start=1", bus.active_frame, bus.commit_pending, bus.frame_start, frameC);
      end
      for (int c = 0; c < 30; c++) begin
         tick();
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL after_edge c=%0d: got vec=%h frame=%h, want vec=%h frame=%h", c, obsVec, bus.active_frame, expVec, mFrame);
         end
      end
   endtask

   task automatic test_disable();
      int guard;
      guard = 0;
      while (expIdx != 37 && guard < LIMIT) begin
         tick();
         guard++;
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL seek37: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
         end
      end
      bus.cfg_enable = 1'b0;
      tick();
      total++;
      if (bus.charlie_index !== 6'd0 || bus.led_on !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL disable_idle: got idx=%0d led=%b busy=%b, want idx=0 led=0 busy=0", bus.charlie_index, bus.led_on, bus.busy);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL disabled c=%0d: got vec=%h frame=%h, want vec=%h frame=%h", c, obsVec, bus.active_frame, expVec, mFrame);
         end
      end
      bus.cfg_enable = 1'b1;
      tick();
      total++;
      if (bus.frame_start !== 1'b1 || bus.charlie_index !== 6'd0 || bus.busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL restart: got start=%b idx=%0d busy=%b, want start=1 idx=0 busy=1", bus.frame_start, bus.charlie_index, bus.busy);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL resumed c=%0d: got vec=%h frame=%h, want vec=%h frame=%h", c, obsVec, bus.active_frame, expVec, mFrame);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         if (bus.cfg_enable == 1'b0) begin
            bus.cfg_dwell      = 8'($urandom_range(0, 5));
            bus.cfg_brightness = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) bus.cfg_enable = 1'b1;
         end else if ($urandom_range(0, 399) == 0) begin
            bus.cfg_enable = 1'b0;
         end
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 1) == 0) bus.frame_in = {$urandom, $urandom};
            else bus.frame_in = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         end
         bus.frame_commit = ($urandom_range(0, 49) == 0);
         tick();
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL random c=%0d: got vec=%h frame=%h, want vec=%h frame=%h", c, obsVec, bus.active_frame, expVec, mFrame);
         end
      end
      bus.frame_commit = 1'b0;
   endtask

   task automatic test_async_reset();
      int guard;
      bus.cfg_enable = 1'b0;
      tick();
      bus.frame_in     = '1;
      bus.frame_commit = 1'b1;
      tick();
      bus.frame_commit   = 1'b0;
      bus.cfg_dwell      = 8'd5;
      bus.cfg_brightness = 8'd6;
      bus.cfg_enable     = 1'b1;
      guard = 0;
      while (!(expIdx == 3 && expPos == 2) && guard < LIMIT) begin
         tick();
         guard++;
         total++;
         if (obsVec !== expVec || bus.active_frame !== mFrame) begin
            bad++;
            $display("[TB] FAIL seek_lit: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
         end
      end
      total++;
      if (bus.led_on !== 1'b1) begin
         bad++;
         $display("[TB] FAIL lit_before_reset: got led=%b, want 1", bus.led_on);
      end
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      total++;
      if (obsVec !== expVec || bus.active_frame !== mFrame || bus.led_on !== 1'b0) begin
         bad++;
         $display("[TB] FAIL async_reset: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
      end
      bus.cfg_enable = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      total++;
      if (obsVec !== expVec || bus.active_frame !== mFrame) begin
         bad++;
         $display("[TB] FAIL post_reset_idle: got vec=%h frame=%h, want vec=%h frame=%h", obsVec, bus.active_frame, expVec, mFrame);
      end
   endtask

   // Runs every scenario in order, then reports the totals.
   initial begin
      test_reset();
      test_dark_scan();
      test_single_led();
      test_mid_frame_commit();
      test_boundary_commit();
      test_disable();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/charlie_scan_scheduler.md
Name: charlie_scan_scheduler

Overview:
Sequences the charlieplex LED driver. It steps the 6-bit LED index through all 64 positions with a programmable dwell and brightness duty. A blanking gap between slots prevents ghosting. Frame updates written over SPI are double-buffered and applied only at a frame boundary, so a frame is never torn. Sits between the SPI register file (config and frame bytes) and the charlieplex output driver.

Parameters:
DWELL_W, 8, width of the dwell and brightness config fields
BLANK_CYCLES, 2, led_on-low gap cycles inserted after every slot (0 is legal: no blank state)
LED_COUNT, 64, number of index positions; fixed 64 for a 6-bit index

Ports:
clk  input  1  system clock
rst_n  input  1  reset, active low
cfg_enable  input  1  scan run enable, level
cfg_dwell  input  DWELL_W  slot length minus 1, in clk cycles
cfg_brightness  input  DWELL_W  on-cycles per slot; a value >= cfg_dwell+1 means fully on
frame_in  input  64  pending frame image from the register file (bit n = LED n)
frame_commit  input  1  one-cycle pulse requesting that frame_in be applied
charlie_index  output  6  current LED index to the driver
led_on  output  1  drive enable for charlie_index; low means all pins off
active_frame  output  64  frame currently displayed
frame_start  output  1  one-cycle pulse on the first cycle of index 0
commit_pending  output  1  commit requested but not yet applied
busy  output  1  high while in SCAN or BLANK

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - charlie_index=0, led_on=0, frame_start=0, commit_pending=0, busy=0
  - active_frame=0
  - state=IDLE, slot counter=0
- All outputs are registered.
- States:
  - IDLE: led_on=0, index held at 0.
    - cfg_enable=1 -> SCAN at index 0 next cycle; frame_start pulses on that first cycle.
  - SCAN: slot counter runs 0..cfg_dwell.
    - led_on = active_frame[charlie_index] && (slot counter < cfg_brightness).
    - At counter==cfg_dwell -> BLANK, or straight to the next slot if BLANK_CYCLES=0.
  - BLANK: led_on=0 for exactly BLANK_CYCLES cycles, then SCAN with index+1.
- Index wrap: 63 -> 0. frame_start=1 on the first SCAN cycle of index 0.
- Cycle count per frame: 64*(cfg_dwell+1+BLANK_CYCLES).
- Config sampling: cfg_dwell and cfg_brightness are sampled at the start of each slot and held for that slot. Mid-slot changes take effect at the next slot.
- Brightness edge cases: cfg_brightness=0 keeps every LED dark while scanning continues.
- Commit handshake:
  - frame_commit sets commit_pending on the next cycle.
  - At a frame boundary (transition into index 0, including IDLE->SCAN) with commit_pending=1: active_frame<=frame_in and commit_pending<=0.
  - frame_in is sampled at the boundary, not at the commit pulse.
  - frame_commit on the boundary cycle itself is applied at that boundary; commit_pending stays 0.
  - Repeated commits before a boundary collapse into one.
  - In IDLE, a commit is applied on the next cycle (no display is running).
- cfg_enable deasserted in any state -> IDLE next cycle. led_on=0 and index=0 at once. active_frame and commit_pending are retained.
- Async reset mid-frame: all state clears immediately and led_on drops the same instant.

Optional Feature:
SCAN_SKIP_EN
- Defined: in SCAN, a slot whose active_frame bit is 0 lasts 1 cycle with led_on=0 and gets no BLANK. Lit slots keep full timing.
  - Frame length = 64 - N + N*(cfg_dwell+1+BLANK_CYCLES), where N = number of lit bits.
  - An all-zero frame scans in 64 cycles.
- Undefined: every slot takes full dwell plus blank regardless of bit value.

Test Plan:
- Reset, then enable with cfg_dwell=3, cfg_brightness=4, BLANK_CYCLES=2, active_frame=0 -> index steps every 6 cycles; led_on stays 0; frame_start every 384 cycles.
- Commit frame_in=64'h1 with dwell=3, brightness=2 -> after next boundary active_frame=1; at index 0, led_on high for 2 cycles then low for 4; other indices dark.
- frame_commit mid-frame at index 20, frame_in changed again at index 50 -> commit_pending=1 until the boundary; active_frame equals the index-50 value; no change mid-frame.
- frame_commit on the exact boundary cycle -> applied that boundary; commit_pending never asserted.
- cfg_enable dropped at index 37 mid-SCAN, then re-raised -> next cycle led_on=0, index=0, busy=0; on restart frame_start pulses and scan resumes from index 0.
- SCAN_SKIP_EN, frame 64'h8000_0000_0000_0001, dwell=3, blank=2 -> frame length 62+12=74 cycles; async rst_n low mid-slot clears led_on immediately.
